// File: rtl/s_machine_pkg.sv
// S-Machine shared definitions: opcodes, instruction fields, FSM states.
package s_machine_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 10;
    localparam int RS_LSB = 8;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    function automatic logic writes_z(input logic [3:0] op);
        return op inside {OP_LDI, OP_LD, OP_ADDI, OP_ADD, OP_SUB,
                          OP_OR, OP_AND, OP_XOR};
    endfunction

    function automatic logic writes_c(input logic [3:0] op);
        return op inside {OP_ADDI, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/s_machine_alu.sv
// S-Machine combinational ALU; C is carry-out for adds, borrow for SUB.
module s_machine_alu
    import s_machine_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = {1'b0, b_i};
        unique case (op_i)
            OP_ADDI, OP_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:          wide = {1'b0, a_i} - {1'b0, b_i};
            OP_OR:           wide = {1'b0, a_i | b_i};
            OP_AND:          wide = {1'b0, a_i & b_i};
            OP_XOR:          wide = {1'b0, a_i ^ b_i};
            default:         wide = {1'b0, b_i};
        endcase
    end

    assign result_o = wide[DATA_W-1:0];
    assign c_o      = wide[DATA_W];
    assign z_o      = (result_o == '0);

endmodule

// File: rtl/s_machine_core.sv
// S-Machine multi-cycle core: FETCH/EXEC/MEM/HALT FSM, register file,
// Z/C flags and a req/ack data-memory port.
module s_machine_core
    import s_machine_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [15:0]       inst,
    output logic [ADDR_W-1:0] PC,
    output logic              mem_req,
    output logic              read_write_memory,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out_memory,
    input  logic [DATA_W-1:0] data_in_memory,
    input  logic              mem_ack,
    output logic              done,
    output logic              halted
);

    localparam int RIW = (NREG > 2) ? 2 : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] dout_q, dout_d, ldat_q, ldat_d;
    logic              z_q, z_d, c_q, c_d;
    logic              req_q, req_d, rw_q, rw_d, ack_q, ack_d;

    logic [3:0]        op;
    logic [7:0]        imm;
    logic [RIW-1:0]    rd, rs;
    logic [ADDR_W-1:0] imm_a, pc_inc;
    logic [DATA_W-1:0] rd_val, rs_val, ld_val, alu_b, alu_res;
    logic              alu_z, alu_c, reg_we, retire;

    assign op     = ir_q[OP_LSB +: 4];
    assign imm    = ir_q[7:0];
    assign rd     = ir_q[RD_LSB +: RIW];
    assign rs     = ir_q[RS_LSB +: RIW];
    assign imm_a  = imm[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);
    assign rd_val = regs_q[rd];
    assign rs_val = regs_q[rs];
    // A load acked while stalled retires later from the captured word
    assign ld_val = ack_q ? ldat_q : data_in_memory;

    always_comb begin
        alu_b = rs_val;
        unique case (op)
            OP_LDI:  alu_b = DATA_W'(imm);
            OP_ADDI: alu_b = DATA_W'($signed(imm));
            OP_LD:   alu_b = ld_val;
            default: alu_b = rs_val;
        endcase
    end

    s_machine_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op),
        .a_i      (rd_val),
        .b_i      (alu_b),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        ldat_d  = ldat_q;
        z_d     = z_q;
        c_d     = c_q;
        req_d   = req_q;
        rw_d    = rw_q;
        ack_d   = ack_q;
        reg_we  = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (enable) begin
                    ir_d    = inst;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (enable) begin
                    unique case (1'b1)
                        (op == OP_LD) || (op == OP_ST): begin
                            req_d   = 1'b1;
                            rw_d    = (op == OP_ST);
                            addr_d  = imm_a;
                            dout_d  = (op == OP_ST) ? rd_val : '0;
                            state_d = ST_MEM;
                        end
                        op == OP_HALT: begin
                            retire  = 1'b1;
                            state_d = ST_HALT;
                        end
                        op == OP_JMP: begin
                            retire  = 1'b1;
                            pc_d    = imm_a;
                            state_d = ST_FETCH;
                        end
                        op == OP_JZ: begin
                            retire  = 1'b1;
                            pc_d    = z_q ? imm_a : pc_inc;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            retire  = 1'b1;
                            reg_we  = writes_z(op);
                            if (writes_z(op)) z_d = alu_z;
                            if (writes_c(op)) c_d = alu_c;
                            pc_d    = pc_inc;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (enable && (mem_ack || ack_q)) begin
                    retire  = 1'b1;
                    if (op == OP_LD) begin
                        reg_we = 1'b1;
                        z_d    = alu_z;
                    end
                    req_d   = 1'b0;
                    rw_d    = 1'b0;
                    addr_d  = '0;
                    dout_d  = '0;
                    ack_d   = 1'b0;
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else if (mem_ack) begin
                    ack_d  = 1'b1;
                    ldat_d = data_in_memory;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            ldat_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            ldat_q  <= ldat_d;
            z_q     <= z_d;
            c_q     <= c_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            ack_q   <= ack_d;
            if (reg_we) regs_q[rd] <= alu_res;
        end
    end

    assign PC                = pc_q;
    assign mem_req           = req_q;
    assign read_write_memory = rw_q;
    assign addr              = addr_q;
    assign data_out_memory   = dout_q;
    assign done              = retire;
    assign halted            = (state_q == ST_HALT);

endmodule

// File: tb/tb_s_machine_core.sv
// Directed bench for s_machine_core: program in a bench-owned ROM, memory
// handshake driven step by step, hand-computed expectations.
module tb_s_machine_core;

    logic        clk = 1'b0;
    logic        rst_n, enable, mem_ack;
    logic [15:0] inst;
    logic [7:0]  PC, addr;
    logic        mem_req, read_write_memory, done, halted;
    logic [15:0] data_out_memory, data_in_memory;
    logic [15:0] rom [256];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    assign inst = rom[PC];

    s_machine_core #(.DATA_W(16), .ADDR_W(8), .NREG(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .inst              (inst),
        .PC                (PC),
        .mem_req           (mem_req),
        .read_write_memory (read_write_memory),
        .addr              (addr),
        .data_out_memory   (data_out_memory),
        .data_in_memory    (data_in_memory),
        .mem_ack           (mem_ack),
        .done              (done),
        .halted            (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec2(input string tag);
        chk({tag, "_fetch_done"}, done, 0);
        tick();
        chk({tag, "_exec_done"}, done, 1);
        tick();
    endtask

    // FETCH then EXEC; returns in the first MEM cycle
    task automatic to_mem(input string tag);
        chk({tag, "_fetch_done"}, done, 0);
        tick();
        chk({tag, "_exec_req"}, mem_req, 0);
        tick();
        chk({tag, "_mem_req"}, mem_req, 1);
    endtask

    task automatic ack_now(input logic [15:0] d);
        mem_ack = 1'b1;
        data_in_memory = d;
        #1;
        chk("ack_done", done, 1);
        tick();
        mem_ack = 1'b0;
        data_in_memory = '0;
        #1;
        chk("after_ack_req", mem_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
        rom[0]  = 16'h0001; rom[1]  = 16'h0401; rom[2]  = 16'h4100;
        rom[3]  = 16'hA040; rom[4]  = 16'h3011; rom[5]  = 16'h0402;
        rom[6]  = 16'h0001; rom[7]  = 16'h5100; rom[8]  = 16'h3010;
        rom[9]  = 16'h5000; rom[10] = 16'hA040;
        rom[8'h40] = 16'h1410; rom[8'h41] = 16'h3411; rom[8'h42] = 16'h1010;
        rom[8'h43] = 16'h3012; rom[8'h44] = 16'h90FF; rom[8'hFF] = 16'hA050;

        rst_n = 1'b0; enable = 1'b1; mem_ack = 1'b0; data_in_memory = '0;
        tick(); tick();
        chk("rst_pc", PC, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_rw", read_write_memory, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dout", data_out_memory, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;

        exec2("ldi_r0"); exec2("ldi_r1"); exec2("add");
        chk("pc_after_add", PC, 3);
        exec2("jz_nt");
        chk("jz_nt_pc", PC, 4);

        to_mem("st_sum");
        chk("st_sum_rw", read_write_memory, 1);
        chk("st_sum_addr", addr, 8'h11);
        chk("st_sum_data", data_out_memory, 16'h0002);
        ack_now(16'h0000);
        chk("st_sum_pc", PC, 5);

        exec2("ldi_r1b"); exec2("ldi_r0b"); exec2("sub_neg");
        to_mem("st_neg");
        chk("st_neg_rw", read_write_memory, 1);
        chk("st_neg_addr", addr, 8'h10);
        chk("st_neg_data", data_out_memory, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_req", mem_req, 1);
            chk("st_wait_done", done, 0);
            tick();
        end
        chk("st_wait_req4", mem_req, 1);
        ack_now(16'h0000);
        chk("st_neg_pc", PC, 9);

        exec2("sub_eq");
        exec2("jz_t");
        chk("jz_t_pc", PC, 8'h40);
        rom[0] = 16'hC000;
        rom[1] = 16'hB000;

        to_mem("ld_r1");
        chk("ld_r1_rw", read_write_memory, 0);
        chk("ld_r1_addr", addr, 8'h10);
        tick();
        chk("ld_r1_wait", done, 0);
        ack_now(16'h1234);
        to_mem("st_r1");
        chk("st_r1_data", data_out_memory, 16'h1234);
        ack_now(16'h0000);

        to_mem("ld_stall");
        enable = 1'b0;
        mem_ack = 1'b1;
        data_in_memory = 16'h00AB;
        #1;
        chk("stall_ack_done", done, 0);
        tick();
        mem_ack = 1'b0;
        data_in_memory = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", mem_req, 1);
            chk("stall_done", done, 0);
            chk("stall_pc", PC, 8'h42);
            tick();
        end
        enable = 1'b1;
        #1;
        chk("resume_done", done, 1);
        tick();
        chk("resume_pc", PC, 8'h43);
        chk("resume_req", mem_req, 0);
        data_in_memory = '0;
        to_mem("st_r0");
        chk("st_r0_data", data_out_memory, 16'h00AB);
        ack_now(16'h0000);

        exec2("jmp");
        chk("jmp_pc", PC, 8'hFF);
        exec2("jz_wrap");
        chk("wrap_pc", PC, 8'h00);
        exec2("nop");
        chk("nop_pc", PC, 8'h01);

        chk("halt_fetch_done", done, 0);
        tick();
        chk("halt_exec_done", done, 1);
        chk("halt_exec_halted", halted, 0);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("halted", halted, 1);
        chk("halt_done", done, 0);
        tick();
        mem_ack = 1'b0;
        tick(); tick();
        chk("halt_pc", PC, 8'h01);
        chk("halt_req", mem_req, 0);
        chk("halt_still", halted, 1);

        rom[0] = 16'h1010;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        to_mem("ld_rst");
        chk("ld_rst_addr", addr, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_pc", PC, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
